// File: rtl/rtr_route_filter_mm_if.sv
// Route filter request/response bundle for one input VC.
// Carries the flit framing, the raw route request, the dimension-order
// change handshake and the filtered route / error outputs.
// Modports:
//   master - upstream routing logic (drives flit/route/mode request inputs)
//   slave  - the route filter itself
// Parameters must match the ones given to the attached rtr_route_filter_mm.
interface rtr_route_filter_mm_if #(
  parameter int num_ports            = 5,
  parameter int num_resource_classes = 2,
  parameter int err_cnt_width        = 8
);
  logic                            flit_valid;
  logic                            flit_head;
  logic                            flit_tail;
  logic                            route_valid;
  logic [num_ports-1:0]            route_in_op;
  logic [num_resource_classes-1:0] route_in_orc;
  logic                            mode_req_valid;
  logic [1:0]                      mode_req;
  logic                            mode_req_ready;
  logic [1:0]                      mode_active;
  logic                            mode_ack;
  logic                            route_out_valid;
  logic [num_ports-1:0]            route_out_op;
  logic [num_resource_classes-1:0] route_out_orc;
  logic [2:0]                      errors;
  logic [err_cnt_width-1:0]        err_count;

  modport master (
    output flit_valid, flit_head, flit_tail, route_valid,
    output route_in_op, route_in_orc, mode_req_valid, mode_req,
    input  mode_req_ready, mode_active, mode_ack,
    input  route_out_valid, route_out_op, route_out_orc, errors, err_count
  );

  modport slave (
    input  flit_valid, flit_head, flit_tail, route_valid,
    input  route_in_op, route_in_orc, mode_req_valid, mode_req,
    output mode_req_ready, mode_active, mode_ack,
    output route_out_valid, route_out_op, route_out_orc, errors, err_count
  );
endinterface

// File: rtl/rtr_route_filter_mm.sv
// Registered multi-mode route filter for one input VC.
// Masks the raw output-port and resource-class request against the turn
// rules of the active dimension order, tracks packet boundaries so that a
// dimension-order change only lands between packets, and reports per-cycle
// and counted routing/protocol errors.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - rtr_route_filter_mm_if.slave (flit framing, route request,
//           mode handshake, filtered route, errors, error counter)
// Mode encoding: 0 ascending, 1 descending, 2 by message class, 3 ignored.
module rtr_route_filter_mm #(
  parameter int         num_message_classes  = 2,
  parameter int         num_resource_classes = 2,
  parameter int         num_vcs_per_class    = 1,
  parameter int         num_dimensions       = 2,
  parameter int         num_nodes_per_router = 1,
  parameter int         num_ports            = 5,
  parameter int         restrict_turns       = 1,
  parameter logic [1:0] reset_mode           = 2'd0,
  parameter int         port_id              = 0,
  parameter int         vc_id                = 0,
  parameter int         err_cnt_width        = 8
) (
  input logic                  clk,
  input logic                  reset,
  rtr_route_filter_mm_if.slave bus
);

  localparam logic [1:0] dim_order_ascending  = 2'd0;
  localparam logic [1:0] dim_order_descending = 2'd1;
  localparam logic [1:0] dim_order_by_class   = 2'd2;
  localparam logic [1:0] dim_order_invalid    = 2'd3;

  localparam int num_net_ports  = 2 * num_dimensions;
  localparam int last_eject     = num_net_ports + num_nodes_per_router - 1;
  localparam int din            = port_id / 2;
  localparam int resource_class = (vc_id / num_vcs_per_class) % num_resource_classes;
  localparam int message_class  =
    (vc_id / (num_vcs_per_class * num_resource_classes)) % num_message_classes;

  typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      mode_active_q, pend_mode_q, pend_mode_d, apply_mode;
  logic                            apply, mode_ack_q;
  logic                            head, tail, req_take, descending;
  logic [num_ports-1:0]            port_mask;
  logic [num_resource_classes-1:0] orc_mask;
  logic [2:0]                      err_d, errors_q;
  logic                            out_valid_q;
  logic [num_ports-1:0]            out_op_q;
  logic [num_resource_classes-1:0] out_orc_q;
  logic [err_cnt_width-1:0]        err_count_q;

  assign head     = bus.flit_valid & bus.flit_head;
  assign tail     = bus.flit_valid & bus.flit_tail;
  // Encoding 3 is handshaked like any request but never changes the mode.
  assign req_take = bus.mode_req_valid & (state_q != PEND) & (bus.mode_req != dim_order_invalid);

  // Resolve the active dimension order into a single direction flag.
  always_comb begin
    descending = 1'b0;
    case (mode_active_q)
      dim_order_ascending:  descending = 1'b0;
      dim_order_descending: descending = 1'b1;
      dim_order_by_class:   descending = (message_class % 2) == 1;
      default:              descending = 1'b0;
    endcase
  end

  // Legal output ports for this input under the active order.
  always_comb begin
    port_mask = '0;
    for (int p = 0; p < num_ports; p++) begin
      if (restrict_turns == 0) begin
        port_mask[p] = 1'b1;
      end else if (port_id >= num_net_ports) begin
        port_mask[p] = (p != port_id);
      end else if (p >= num_net_ports) begin
        port_mask[p] = (p <= last_eject);
      end else if (p == (port_id ^ 1)) begin
        port_mask[p] = 1'b1;
      end else if (descending) begin
        port_mask[p] = (p / 2) < din;
      end else begin
        port_mask[p] = (p / 2) > din;
      end
    end
  end

  // Resource classes may only stay or move upwards.
  always_comb begin
    orc_mask = '0;
    for (int r = 0; r < num_resource_classes; r++) begin
      orc_mask[r] = (restrict_turns == 0) || (r >= resource_class);
    end
  end

  // Per-cycle error classification, registered below.
  always_comb begin
    err_d    = '0;
    err_d[0] = bus.route_valid &
               (!$onehot(bus.route_in_op) || ((bus.route_in_op & ~port_mask) != '0));
    err_d[1] = bus.route_valid &
               (!$onehot(bus.route_in_orc) || ((bus.route_in_orc & ~orc_mask) != '0));
    err_d[2] = (head && (state_q != IDLE)) ||
               (bus.flit_valid && !head && (state_q == IDLE)) ||
               (bus.route_valid && !head);
  end

  // Packet tracking and mode scheduling. A request that arrives while a
  // packet stays open is parked until the tail; otherwise it applies at
  // once. A request coinciding with the tail of an open packet applies
  // immediately since the packet is finished at that edge.
  always_comb begin
    state_d     = state_q;
    pend_mode_d = pend_mode_q;
    apply       = 1'b0;
    apply_mode  = bus.mode_req;
    case (state_q)
      IDLE: begin
        if (head && !tail) begin
          state_d = BUSY;
          if (req_take) begin
            pend_mode_d = bus.mode_req;
            state_d     = PEND;
          end
        end else if (req_take) begin
          apply = 1'b1;
        end
      end
      BUSY: begin
        if (tail) begin
          state_d = IDLE;
          apply   = req_take;
        end else if (req_take) begin
          pend_mode_d = bus.mode_req;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (tail) begin
          state_d    = IDLE;
          apply      = 1'b1;
          apply_mode = pend_mode_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, active mode and acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_mode_q   <= dim_order_ascending;
      mode_active_q <= reset_mode;
      mode_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_mode_q <= pend_mode_d;
      mode_ack_q  <= apply;
      if (apply) begin
        mode_active_q <= apply_mode;
      end
    end
  end

  // Registered filtered route, errors and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_orc_q   <= '0;
      errors_q    <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= bus.route_valid;
      out_op_q    <= bus.route_in_op & port_mask;
      out_orc_q   <= bus.route_in_orc & orc_mask;
      errors_q    <= err_d;
      if ((err_d != '0) && (err_count_q != '1)) begin
        err_count_q <= err_count_q + err_cnt_width'(1);
      end
    end
  end

  assign bus.mode_req_ready  = (state_q != PEND);
  assign bus.mode_active     = mode_active_q;
  assign bus.mode_ack        = mode_ack_q;
  assign bus.route_out_valid = out_valid_q;
  assign bus.route_out_op    = out_op_q;
  assign bus.route_out_orc   = out_orc_q;
  assign bus.errors          = errors_q;
  assign bus.err_count       = err_count_q;

endmodule

// File: tb/tb_rtr_route_filter_mm.sv
// Self-checking bench for rtr_route_filter_mm. Four instances share one
// stimulus stream: network input 0 / VC 0, network input 3 / VC 3
// (message class 1, resource class 1), injection input 4 / VC 1 and an
// unrestricted copy of input 0. A packet-level reference model predicts
// every registered output of every instance.
module tb_rtr_route_filter_mm;
  localparam int NP   = 5;
  localparam int NRC  = 2;
  localparam int NMC  = 2;
  localparam int NVC  = 1;
  localparam int ND   = 2;
  localparam int CW   = 8;
  localparam int NDUT = 4;
  localparam int port_ids  [NDUT] = '{0, 3, 4, 0};
  localparam int vc_ids    [NDUT] = '{0, 3, 1, 0};
  localparam int restricts [NDUT] = '{1, 1, 1, 0};

  typedef struct {
    logic           fv, fh, ft, rv;
    logic [NP-1:0]  op;
    logic [NRC-1:0] orc;
    logic           mrv;
    logic [1:0]     mr;
  } stim_t;

  typedef struct {
    stim_t          s;
    logic [NP-1:0]  op0;
    logic [2:0]     err0;
    logic [1:0]     active;
    logic           ack;
    logic           ready;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           flit_valid, flit_head, flit_tail, route_valid, mode_req_valid;
  logic [NP-1:0]  route_in_op;
  logic [NRC-1:0] route_in_orc;
  logic [1:0]     mode_req;

  logic           o_valid  [NDUT];
  logic [NP-1:0]  o_op     [NDUT];
  logic [NRC-1:0] o_orc    [NDUT];
  logic [2:0]     o_err    [NDUT];
  logic [CW-1:0]  o_cnt    [NDUT];
  logic           o_ready  [NDUT];
  logic [1:0]     o_active [NDUT];
  logic           o_ack    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rtr_route_filter_mm_if #(.num_ports(NP), .num_resource_classes(NRC), .err_cnt_width(CW)) bus ();
    assign bus.flit_valid     = flit_valid;
    assign bus.flit_head      = flit_head;
    assign bus.flit_tail      = flit_tail;
    assign bus.route_valid    = route_valid;
    assign bus.route_in_op    = route_in_op;
    assign bus.route_in_orc   = route_in_orc;
    assign bus.mode_req_valid = mode_req_valid;
    assign bus.mode_req       = mode_req;
    rtr_route_filter_mm #(
      .num_message_classes(NMC), .num_resource_classes(NRC), .num_vcs_per_class(NVC),
      .num_dimensions(ND), .num_nodes_per_router(1), .num_ports(NP),
      .restrict_turns(restricts[g]), .reset_mode(2'd0), .port_id(port_ids[g]),
      .vc_id(vc_ids[g]), .err_cnt_width(CW)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
    assign o_valid[g]  = bus.route_out_valid;
    assign o_op[g]     = bus.route_out_op;
    assign o_orc[g]    = bus.route_out_orc;
    assign o_err[g]    = bus.errors;
    assign o_cnt[g]    = bus.err_count;
    assign o_ready[g]  = bus.mode_req_ready;
    assign o_active[g] = bus.mode_active;
    assign o_ack[g]    = bus.mode_ack;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Reference model state: packet open flag, parked mode, applied mode.
  bit         m_in_packet;
  bit         m_pend_valid;
  logic [1:0] m_pend_mode;
  logic [1:0] m_mode;
  logic           e_valid [NDUT];
  logic [NP-1:0]  e_op    [NDUT];
  logic [NRC-1:0] e_orc   [NDUT];
  logic [2:0]     e_err   [NDUT];
  int             e_cnt   [NDUT];
  logic [1:0]     e_active;
  logic           e_ack;
  logic           e_ready;

  function automatic logic [NP-1:0] modelPortMask(int pid, int vc, int restr, logic [1:0] mode);
    logic [NP-1:0] m;
    int  mc;
    bit  desc;
    if (restr == 0) return '1;
    mc   = (vc / (NVC * NRC)) % NMC;
    desc = (mode == 2'd1) || (mode == 2'd2 && (mc % 2) == 1);
    m    = '0;
    for (int p = 0; p < NP; p++) begin
      if (pid >= 2 * ND)        m[p] = (p != pid);
      else if (p >= 2 * ND)     m[p] = 1'b1;
      else if (p == (pid ^ 1))  m[p] = 1'b1;
      else if (desc)            m[p] = (p / 2) < (pid / 2);
      else                      m[p] = (p / 2) > (pid / 2);
    end
    return m;
  endfunction

  function automatic logic [NRC-1:0] modelOrcMask(int vc, int restr);
    logic [NRC-1:0] m;
    int rc;
    rc = (vc / NVC) % NRC;
    m  = '0;
    for (int r = 0; r < NRC; r++) m[r] = (restr == 0) || (r >= rc);
    return m;
  endfunction

  task automatic modelReset();
    m_in_packet  = 0;
    m_pend_valid = 0;
    m_pend_mode  = 2'd0;
    m_mode       = 2'd0;
    for (int i = 0; i < NDUT; i++) begin
      e_valid[i] = 0; e_op[i] = '0; e_orc[i] = '0; e_err[i] = '0; e_cnt[i] = 0;
    end
    e_active = 2'd0;
    e_ack    = 0;
    e_ready  = 1;
  endtask

  task automatic checkOne(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, idx, cycle, act, exp);
  endtask

  // Drives one cycle, advances the model across the edge, and returns on
  // the following falling edge where outputs are stable.
  task automatic applyStimulus(input stim_t s);
    bit head, tail, proto, open_after;
    logic [NP-1:0]  pm;
    logic [NRC-1:0] om;
    head  = s.fv && s.fh;
    tail  = s.fv && s.ft;
    proto = (head && m_in_packet) || (s.fv && !head && !m_in_packet) || (s.rv && !head);
    for (int i = 0; i < NDUT; i++) begin
      pm = modelPortMask(port_ids[i], vc_ids[i], restricts[i], m_mode);
      om = modelOrcMask(vc_ids[i], restricts[i]);
      e_valid[i]  = s.rv;
      e_op[i]     = s.op & pm;
      e_orc[i]    = s.orc & om;
      e_err[i][0] = s.rv && ($countones(s.op) != 1 || (s.op & ~pm) != '0);
      e_err[i][1] = s.rv && ($countones(s.orc) != 1 || (s.orc & ~om) != '0);
      e_err[i][2] = proto;
      if (e_err[i] != 3'b000 && e_cnt[i] < (1 << CW) - 1) e_cnt[i]++;
    end
    open_after = m_in_packet ? !tail : (head && !tail);
    e_ack = 0;
    if (m_pend_valid) begin
      if (tail) begin
        m_mode = m_pend_mode; m_pend_valid = 0; e_ack = 1;
      end
    end else if (s.mrv && s.mr != 2'd3) begin
      if (open_after) begin
        m_pend_mode = s.mr; m_pend_valid = 1;
      end else begin
        m_mode = s.mr; e_ack = 1;
      end
    end
    m_in_packet = open_after;
    e_active = m_mode;
    e_ready  = !m_pend_valid;

    flit_valid = s.fv; flit_head = s.fh; flit_tail = s.ft; route_valid = s.rv;
    route_in_op = s.op; route_in_orc = s.orc; mode_req_valid = s.mrv; mode_req = s.mr;
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NDUT; i++) begin
      checkOne("route_out_valid", i, 32'(o_valid[i]), 32'(e_valid[i]));
      checkOne("route_out_op", i, 32'(o_op[i]), 32'(e_op[i]));
      checkOne("route_out_orc", i, 32'(o_orc[i]), 32'(e_orc[i]));
      checkOne("errors", i, 32'(o_err[i]), 32'(e_err[i]));
      checkOne("err_count", i, 32'(o_cnt[i]), 32'(e_cnt[i]));
      checkOne("mode_active", i, 32'(o_active[i]), 32'(e_active));
      checkOne("mode_ack", i, 32'(o_ack[i]), 32'(e_ack));
      checkOne("mode_req_ready", i, 32'(o_ready[i]), 32'(e_ready));
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      checkOne({tag, "_valid"}, i, 32'(o_valid[i]), 0);
      checkOne({tag, "_op"}, i, 32'(o_op[i]), 0);
      checkOne({tag, "_orc"}, i, 32'(o_orc[i]), 0);
      checkOne({tag, "_errors"}, i, 32'(o_err[i]), 0);
      checkOne({tag, "_err_count"}, i, 32'(o_cnt[i]), 0);
      checkOne({tag, "_ack"}, i, 32'(o_ack[i]), 0);
      checkOne({tag, "_ready"}, i, 32'(o_ready[i]), 1);
      checkOne({tag, "_active"}, i, 32'(o_active[i]), 0);
    end
  endtask

  function automatic stim_t mk(logic fv, logic fh, logic ft, logic rv, logic [NP-1:0] op,
                               logic [NRC-1:0] orc, logic mrv, logic [1:0] mr);
    stim_t s;
    s.fv = fv; s.fh = fh; s.ft = ft; s.rv = rv; s.op = op; s.orc = orc; s.mrv = mrv; s.mr = mr;
    return s;
  endfunction

  vec_t  tbl [14];
  stim_t idle_s, rs;

  initial begin
    // Expected columns are for instance 0 (input 0, VC 0, restricted).
    tbl[0]  = '{mk(1,1,1,1,5'b00100,2'b01,0,2'd0), 5'b00100, 3'b000, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{mk(1,1,1,1,5'b00001,2'b01,0,2'd0), 5'b00000, 3'b001, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{mk(0,0,0,0,5'b00000,2'b00,1,2'd1), 5'b00000, 3'b000, 2'd1, 1'b1, 1'b1};
    tbl[3]  = '{mk(1,1,1,1,5'b01000,2'b01,0,2'd0), 5'b00000, 3'b001, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{mk(1,1,1,1,5'b10000,2'b10,0,2'd0), 5'b10000, 3'b000, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{mk(1,1,0,1,5'b00010,2'b01,0,2'd0), 5'b00010, 3'b000, 2'd1, 1'b0, 1'b1};
    tbl[6]  = '{mk(1,0,0,0,5'b00000,2'b00,1,2'd0), 5'b00000, 3'b000, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{mk(1,0,0,0,5'b00000,2'b00,1,2'd1), 5'b00000, 3'b000, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{mk(1,0,1,0,5'b00000,2'b00,0,2'd0), 5'b00000, 3'b000, 2'd0, 1'b1, 1'b1};
    tbl[9]  = '{mk(1,0,1,0,5'b00000,2'b00,0,2'd0), 5'b00000, 3'b100, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{mk(0,0,0,1,5'b00100,2'b01,0,2'd0), 5'b00100, 3'b100, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{mk(0,0,0,0,5'b00000,2'b00,1,2'd3), 5'b00000, 3'b000, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{mk(1,1,1,1,5'b00110,2'b11,0,2'd0), 5'b00110, 3'b011, 2'd0, 1'b0, 1'b1};
    tbl[13] = '{mk(1,1,1,1,5'b01000,2'b01,0,2'd0), 5'b01000, 3'b000, 2'd0, 1'b0, 1'b1};
    idle_s  = mk(0,0,0,0,5'b00000,2'b00,0,2'd0);

    flit_valid = 0; flit_head = 0; flit_tail = 0; route_valid = 0;
    route_in_op = '0; route_in_orc = '0; mode_req_valid = 0; mode_req = 2'd0;
    reset = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    $display("[TB] directed vector table");
    for (int k = 0; k < 14; k++) begin
      applyStimulus(tbl[k].s);
      checkOutput();
      checkOne("tbl_op", k, 32'(o_op[0]), 32'(tbl[k].op0));
      checkOne("tbl_errors", k, 32'(o_err[0]), 32'(tbl[k].err0));
      checkOne("tbl_active", k, 32'(o_active[0]), 32'(tbl[k].active));
      checkOne("tbl_ack", k, 32'(o_ack[0]), 32'(tbl[k].ack));
      checkOne("tbl_ready", k, 32'(o_ready[0]), 32'(tbl[k].ready));
    end

    $display("[TB] error counter saturation");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(mk(1,0,1,0,5'b00000,2'b00,0,2'd0));
      checkOutput();
    end
    for (int i = 0; i < NDUT; i++) checkOne("err_count_sat", i, 32'(o_cnt[i]), 255);

    $display("[TB] reset while a mode change is pending");
    applyStimulus(mk(1,1,0,1,5'b00100,2'b01,0,2'd0));
    checkOutput();
    applyStimulus(mk(1,0,0,0,5'b00000,2'b00,1,2'd1));
    checkOutput();
    checkOne("pend_ready", 0, 32'(o_ready[0]), 0);
    flit_valid = 0; mode_req_valid = 0; route_valid = 0;
    #2 reset = 1'b1;
    #1 checkResetState("async_reset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mk(1,0,1,0,5'b00000,2'b00,0,2'd0));
    checkOutput();
    checkOne("pend_lost_active", 0, 32'(o_active[0]), 0);
    checkOne("pend_lost_ack", 0, 32'(o_ack[0]), 0);
    checkOne("idle_tail_err", 0, 32'(o_err[0]), 32'(3'b100));

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      rs.fv  = ($urandom_range(0, 3) != 0);
      rs.fh  = ($urandom_range(0, 2) == 0);
      rs.ft  = ($urandom_range(0, 2) == 0);
      rs.rv  = (rs.fv && rs.fh) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      rs.op  = ($urandom_range(0, 1) == 0) ? NP'(1 << $urandom_range(0, NP - 1)) : NP'($urandom);
      rs.orc = ($urandom_range(0, 1) == 0) ? NRC'(1 << $urandom_range(0, NRC - 1)) : NRC'($urandom);
      rs.mrv = ($urandom_range(0, 5) == 0);
      rs.mr  = 2'($urandom_range(0, 3));
      applyStimulus(rs);
      checkOutput();
    end
    applyStimulus(idle_s);
    checkOutput();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
